// File: rtl/regfile_pkg.sv
// Shared regfile writeback types and constants.
// Imported by the writeback arbiter and its hold slots.
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 15;
  localparam int PC_IDX     = 15;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic is_pc(
    input logic [REG_ADDR_W-1:0] d
  );
    return d == REG_ADDR_W'(PC_IDX);
  endfunction

  function automatic logic [NUM_REGS-1:0] dest_onehot(
    input logic                  v,
    input logic [REG_ADDR_W-1:0] d
  );
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      r[i] = v && (d == REG_ADDR_W'(i));
    return r;
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback hold buffer with valid/ready input.
// Drains on pop (granted) or flush (discarded), refill allowed same cycle.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    pop,
  input  logic    flush,
  output logic    ready,
  output logic    valid,
  output wb_req_t req
);

  logic load;

  assign ready = !valid || pop;
  assign load  = in_valid && ready;

  // Entry register: load wins over drain so a granted slot can refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= in_req;
    end else if (pop || flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source regfile writeback arbiter, MEM over ALU, same-dest age order.
// Optional ALU starvation guard enabled by macro WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  drop_pc
);

  wb_req_t alu_in, mem_in, alu_q, mem_q;
  logic    alu_v, mem_v;
  logic    alu_live, mem_live;
  logic    alu_drop, mem_drop;
  logic    alu_gnt, mem_gnt;
  logic    alu_load, mem_load;
  logic    mem_older;
  logic    starve;

  assign alu_in = '{dest: alu_dest, data: alu_data};
  assign mem_in = '{dest: mem_dest, data: mem_data};

  wb_hold_slot u_alu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (alu_valid),
    .in_req   (alu_in),
    .pop      (alu_gnt),
    .flush    (alu_drop),
    .ready    (alu_ready),
    .valid    (alu_v),
    .req      (alu_q)
  );

  wb_hold_slot u_mem_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (mem_valid),
    .in_req   (mem_in),
    .pop      (mem_gnt),
    .flush    (mem_drop),
    .ready    (mem_ready),
    .valid    (mem_v),
    .req      (mem_q)
  );

  assign alu_drop = alu_v && is_pc(alu_q.dest);
  assign mem_drop = mem_v && is_pc(mem_q.dest);
  assign alu_live = alu_v && !alu_drop;
  assign mem_live = mem_v && !mem_drop;
  assign alu_load = alu_valid && alu_ready;
  assign mem_load = mem_valid && mem_ready;

`ifdef WB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starve = starve_cnt == CNT_W'(STARVE_LIMIT);

  // Count consecutive cycles a live ALU entry loses arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (!alu_live || alu_gnt)
      starve_cnt <= '0;
    else if (!starve)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve = 1'b0;
`endif

  // Track which slot holds the older entry; MEM wins a same-edge tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mem_older <= 1'b0;
    else if (alu_load)
      mem_older <= 1'b1;
    else if (mem_load)
      mem_older <= 1'b0;
  end

  // Pulse drop_pc the cycle after any PC-targeted entry is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_pc <= 1'b0;
    else
      drop_pc <= alu_drop || mem_drop;
  end

  // Grant select: age order on equal dest, else MEM unless ALU starved.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    unique case (1'b1)
      alu_live && mem_live && (alu_q.dest == mem_q.dest): begin
        if (mem_older) mem_gnt = 1'b1;
        else           alu_gnt = 1'b1;
      end
      alu_live && mem_live && (alu_q.dest != mem_q.dest): begin
        if (starve) alu_gnt = 1'b1;
        else        mem_gnt = 1'b1;
      end
      alu_live && !mem_live: alu_gnt = 1'b1;
      mem_live && !alu_live: mem_gnt = 1'b1;
      default: ;
    endcase
  end

  // Drive the single regfile write port from the granted slot.
  always_comb begin
    wb_en   = alu_gnt || mem_gnt;
    wb_dest = '0;
    wb_data = '0;
    if (mem_gnt) begin
      wb_dest = mem_q.dest;
      wb_data = mem_q.data;
    end else if (alu_gnt) begin
      wb_dest = alu_q.dest;
      wb_data = alu_q.data;
    end
  end

  assign busy = dest_onehot(alu_live, alu_q.dest)
              | dest_onehot(mem_live, mem_q.dest);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Follows WB_STARVE_GUARD_EN the same way the design does.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int LIMIT = 3;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic [14:0] busy;
  logic        drop_pc;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .busy      (busy),
    .drop_pc   (drop_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Pending-write model: each requester holds at most one entry,
  // stamped with the first cycle it is resident.
  typedef struct {
    bit          v;
    logic [3:0]  d;
    logic [31:0] x;
    int          t;
  } ent_t;

  ent_t        ma, mm;
  bit          mdrop;
  int          cyc;
  logic [31:0] dut_rf [16];

  always @(negedge clk) begin : model
    bit          al, ml, ga, gm, ra, rm;
    logic [3:0]  ed;
    logic [31:0] ex;
    logic [14:0] eb;
    cyc++;
    if (wb_en) dut_rf[wb_dest] = wb_data;
    if (!rst) begin
      ma.v  = 1'b0;
      mm.v  = 1'b0;
      mdrop = 1'b0;
    end
    al = ma.v && ma.d != 4'd15;
    ml = mm.v && mm.d != 4'd15;
    ga = 1'b0;
    gm = 1'b0;
    if (al && ml) begin
      if (ma.d == mm.d) begin
        if (mm.t <= ma.t) gm = 1'b1;
        else              ga = 1'b1;
      end else if (GUARD && (cyc - ma.t) >= LIMIT) ga = 1'b1;
      else gm = 1'b1;
    end else if (al) ga = 1'b1;
    else if (ml) gm = 1'b1;
    ed = gm ? mm.d : (ga ? ma.d : 4'd0);
    ex = gm ? mm.x : (ga ? ma.x : 32'd0);
    eb = '0;
    if (al) eb = eb | (15'(1) << ma.d);
    if (ml) eb = eb | (15'(1) << mm.d);
    ra = !ma.v || ga;
    rm = !mm.v || gm;
    chk("m_wb_en", {31'd0, wb_en}, {31'd0, ga | gm});
    chk("m_wb_dest", {28'd0, wb_dest}, {28'd0, ed});
    chk("m_wb_data", wb_data, ex);
    chk("m_busy", {17'd0, busy}, {17'd0, eb});
    chk("m_alu_ready", {31'd0, alu_ready}, {31'd0, ra});
    chk("m_mem_ready", {31'd0, mem_ready}, {31'd0, rm});
    chk("m_drop_pc", {31'd0, drop_pc}, {31'd0, mdrop});
    if (rst) begin
      mdrop = (ma.v && ma.d == 4'd15) || (mm.v && mm.d == 4'd15);
      if (ga || (ma.v && ma.d == 4'd15)) ma.v = 1'b0;
      if (gm || (mm.v && mm.d == 4'd15)) mm.v = 1'b0;
      if (alu_valid && ra) ma = '{1'b1, alu_dest, alu_data, cyc + 1};
      if (mem_valid && rm) mm = '{1'b1, mem_dest, mem_data, cyc + 1};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic alu_req(input logic [3:0] d, input logic [31:0] x);
    alu_valid = 1'b1;
    alu_dest  = d;
    alu_data  = x;
  endtask

  task automatic mem_req(input logic [3:0] d, input logic [31:0] x);
    mem_valid = 1'b1;
    mem_dest  = d;
    mem_data  = x;
  endtask

  initial begin
    int first;
    for (int i = 0; i < 16; i++) dut_rf[i] = 32'hDEAD0000 | 32'(i);
    #1 rst = 1'b0;
    #1;
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_busy", {17'd0, busy}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_drop_pc", {31'd0, drop_pc}, 32'd0);
    step();
    step();
    rst = 1'b1;

    // single ALU write
    step();
    alu_req(4'd3, 32'hA5);
    step();
    idle();
    chk("single_wb_en", {31'd0, wb_en}, 32'd1);
    chk("single_dest", {28'd0, wb_dest}, 32'd3);
    chk("single_data", wb_data, 32'hA5);
    chk("single_busy", {17'd0, busy}, 32'h0008);
    step();
    chk("single_after_busy", {17'd0, busy}, 32'd0);
    chk("single_after_en", {31'd0, wb_en}, 32'd0);

    // MEM priority, different dest
    alu_req(4'd2, 32'h222);
    mem_req(4'd5, 32'h555);
    step();
    idle();
    chk("prio_first_dest", {28'd0, wb_dest}, 32'd5);
    chk("prio_first_data", wb_data, 32'h555);
    chk("prio_alu_ready", {31'd0, alu_ready}, 32'd0);
    step();
    chk("prio_second_dest", {28'd0, wb_dest}, 32'd2);
    chk("prio_second_data", wb_data, 32'h222);
    step();
    chk("prio_idle_en", {31'd0, wb_en}, 32'd0);

    // same dest, same-cycle acceptance
    alu_req(4'd7, 32'h11);
    mem_req(4'd7, 32'h22);
    step();
    idle();
    chk("same_first_data", wb_data, 32'h22);
    step();
    chk("same_second_data", wb_data, 32'h11);
    step();
    chk("same_final_r7", dut_rf[7], 32'h11);

    // ALU starvation under a streaming MEM
    first = -1;
    alu_req(4'd1, 32'h77);
    mem_req(4'd8, 32'h100);
    step();
    alu_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (wb_en && wb_dest == 4'd1 && first < 0) first = k;
      mem_data = mem_data + 32'd1;
      step();
    end
    mem_valid = 1'b0;
    chk("starve_grant_cycle", 32'(first), GUARD ? 32'd3 : 32'hFFFFFFFF);
    step();
    step();
    step();
    chk("starve_final_r1", dut_rf[1], 32'h77);

    // PC-targeted requests are dropped
    mem_req(4'd15, 32'hBEEF);
    step();
    idle();
    chk("drop_no_wb", {31'd0, wb_en}, 32'd0);
    chk("drop_busy", {17'd0, busy}, 32'd0);
    chk("drop_pending", {31'd0, drop_pc}, 32'd0);
    step();
    chk("drop_pulse", {31'd0, drop_pc}, 32'd1);
    chk("drop_pulse_no_wb", {31'd0, wb_en}, 32'd0);
    step();
    chk("drop_pulse_end", {31'd0, drop_pc}, 32'd0);
    alu_req(4'd15, 32'h1);
    mem_req(4'd15, 32'h2);
    step();
    idle();
    step();
    chk("drop_both_pulse", {31'd0, drop_pc}, 32'd1);
    step();
    chk("drop_both_end", {31'd0, drop_pc}, 32'd0);
    alu_req(4'd4, 32'h44);
    mem_req(4'd15, 32'h3);
    step();
    idle();
    chk("drop_mix_dest", {28'd0, wb_dest}, 32'd4);
    step();
    chk("drop_mix_pulse", {31'd0, drop_pc}, 32'd1);
    step();

    // reset with both slots full
    alu_req(4'd9, 32'h99);
    mem_req(4'd10, 32'hAA);
    step();
    idle();
    chk("mid_busy", {17'd0, busy}, 32'h0600);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("mid_rst_busy", {17'd0, busy}, 32'd0);
    chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_after_en", {31'd0, wb_en}, 32'd0);
    chk("mid_r9_untouched", dut_rf[9], 32'hDEAD0009);
    chk("mid_r10_untouched", dut_rf[10], 32'hDEAD000A);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive denied cycles of a full ALU slot before ALU is forced.
REQ-002 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid in 1, alu_dest in 4, alu_data in 32: ALU writeback request.
REQ-005 SHALL have port alu_ready  out  1  ALU slot can accept this cycle.
REQ-006 SHALL have ports mem_valid in 1, mem_dest in 4, mem_data in 32: load writeback request.
REQ-007 SHALL have port mem_ready  out  1  MEM slot can accept this cycle.
REQ-008 SHALL have ports wb_en out 1, wb_dest out 4, wb_data out 32: single regfile write port (regfile samples on negedge).
REQ-009 SHALL have port busy  out  15  bit r set while any slot holds a pending write to r (r=0..14).
REQ-010 SHALL have port drop_pc  out  1  one-cycle pulse: a request to dest 15 was discarded.

Function
REQ-011 SHALL hold one entry per requester (ALU slot, MEM slot); accept on valid&&ready at posedge.
REQ-012 SHALL drive ready = slot empty OR slot granted this cycle (same-cycle drain-and-refill allowed).
REQ-013 SHALL drive wb_en/wb_dest/wb_data combinationally from the granted slot; latency accept-to-wb_en = 1 cycle; slot clears at the following posedge unless refilled.
REQ-014 SHALL grant at most one slot per cycle; wb_en=0, wb_dest=0, wb_data=0 when nothing granted.
REQ-015 SHALL by default grant MEM over ALU when both slots full.
REQ-016 SHALL, when both slots full with equal dest, grant the older entry first regardless of priority; same-cycle acceptance counts MEM as older.
REQ-017 SHALL keep a starvation counter: increments each cycle the ALU slot is full and not granted; clears on ALU grant or ALU slot empty; saturates at STARVE_LIMIT.
REQ-018 SHALL grant ALU when counter equals STARVE_LIMIT, unless REQ-016 requires MEM (same dest, MEM older).
REQ-019 SHALL accept requests with dest 15, never grant them, discard at the next posedge, and assert drop_pc for exactly the following cycle; simultaneous drops from both ports give one pulse.
REQ-020 SHALL compute busy as the OR of one-hot decodes of valid slot dests (0..14) from current slot state; dest 15 never sets busy.

Reset
REQ-021 SHALL on rst low asynchronously empty both slots, clear age bit and starvation counter, and drive wb_en=0, drop_pc=0, busy=0, alu_ready=1, mem_ready=1.
REQ-022 SHALL discard pending entries on reset mid-operation; no write issued in the reset cycle.

Configuration
REQ-023 SHALL honour macro WB_STARVE_GUARD_EN: defined -> REQ-017/018 active; undefined -> counter absent, pure MEM-over-ALU priority with REQ-016 ordering still applied.

Structure
REQ-024 SHALL take REG_ADDR_W=4, DATA_W=32, NUM_REGS=15, PC_IDX=15 and a wb_req_t struct (dest, data) from shared package regfile_pkg.
REQ-025 SHALL implement each slot as sub-module wb_hold_slot (one-entry buffer, valid/ready, load/clear), instantiated twice.

Verification
REQ-026 Single ALU req dest 3 data 0xA5 -> wb_en=1, wb_dest=3, wb_data=0xA5 next cycle; busy[3]=1 that cycle only.
REQ-027 ALU dest 2 and MEM dest 5 same cycle -> MEM written cycle+1, ALU cycle+2; alu_ready=0 in cycle+1.
REQ-028 Same-cycle ALU 0x11 and MEM 0x22 both dest 7 -> MEM written first, then ALU; final r7=0x11.
REQ-029 Guard on, STARVE_LIMIT=3, MEM valid every cycle, ALU dest 1 held -> ALU granted on 4th cycle after acceptance; guard off -> ALU never granted while MEM streams.
REQ-030 MEM req dest 15 -> no wb_en, drop_pc pulse 1 cycle, busy=0; rst low with both slots full -> wb_en=0, busy=0 immediately.
